// File: rtl/ram_loader_pkg.sv
// Shared definitions for the boot-time RAM loader: bus/address defaults and FSM encoding.
package ram_loader_pkg;

    // Defaults shared with the CPU RAM instance so both sides agree on geometry.
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 4;
    localparam int unsigned DEFAULT_WIDTH         = 8;

    // Loader FSM states, fixed 3-bit encoding.
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLen      = 3'd1,
        StWaitByte = 3'd2,
        StAddr     = 3'd3,
        StWrite    = 3'd4,
        StDone     = 3'd5
    } loader_state_e;

endpackage

// File: rtl/ram_loader_if.sv
// Stream handshake, control/status and shared-bus signals of the RAM loader.
interface ram_loader_if #(
    parameter int unsigned WIDTH = ram_loader_pkg::DEFAULT_WIDTH
);
    // Host / stream side
    logic             start;
    logic             byte_valid;
    logic [WIDTH-1:0] byte_data;
    logic             byte_ready;
    logic             done;
    logic             length_error;
    // Shared bus / RAM / CPU side
    logic [WIDTH-1:0] bus_out;
    logic             ram_addr_enable;
    logic             ram_write_enable;
    logic             cpu_hold;

    // Loader end
    modport master (
        input  start, byte_valid, byte_data,
        output byte_ready, done, length_error,
        output bus_out, ram_addr_enable, ram_write_enable, cpu_hold
    );

    // Host end (stream source, RAM and CPU observers)
    modport slave (
        output start, byte_valid, byte_data,
        input  byte_ready, done, length_error,
        input  bus_out, ram_addr_enable, ram_write_enable, cpu_hold
    );
endinterface

// File: rtl/ram_loader.sv
// Boot-time loader: takes a length-prefixed byte stream and writes the payload into
// consecutive RAM words from address 0 over the shared OR-bus, holding the CPU off meanwhile.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned MEMORY_SIZE   = 1 << ADDRESS_WIDTH
) (
    input  logic       clk,
    input  logic       reset_n,
    ram_loader_if.master ldr
);

    localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;

    localparam logic [WIDTH-1:0] MEM_SIZE_W = WIDTH'(MEMORY_SIZE);
    localparam logic [CNT_W-1:0] MEM_SIZE_C = CNT_W'(MEMORY_SIZE);

    loader_state_e    state_q, state_d;
    logic [CNT_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             length_error_q, length_error_d;

    logic             byte_ready;
    logic [WIDTH-1:0] bus_out;
    logic             ram_addr_enable;
    logic             ram_write_enable;
    logic             cpu_hold;

    // State and datapath registers; reset drops the bus immediately via the Moore decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            addr_cnt_q     <= '0;
            remaining_q    <= '0;
            data_q         <= '0;
            done_q         <= 1'b0;
            length_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_cnt_q     <= addr_cnt_d;
            remaining_q    <= remaining_d;
            data_q         <= data_d;
            done_q         <= done_d;
            length_error_q <= length_error_d;
        end
    end

    // Next-state logic: header capture, byte latch, address/write sequencing.
    always_comb begin
        state_d        = state_q;
        addr_cnt_d     = addr_cnt_q;
        remaining_d    = remaining_q;
        data_d         = data_q;
        done_d         = done_q;
        length_error_d = length_error_q;

        unique case (state_q)
            StIdle: begin
                done_d         = 1'b0;
                length_error_d = 1'b0;
                addr_cnt_d     = '0;
                if (ldr.start) state_d = StLen;
            end
            StLen: begin
                if (ldr.byte_valid) begin
                    if (ldr.byte_data > MEM_SIZE_W) begin
                        length_error_d = 1'b1;
                        state_d        = StDone;
                    end else begin
                        // A zero header means a full-memory load.
                        remaining_d = (ldr.byte_data == '0) ? MEM_SIZE_C
                                                            : ldr.byte_data[CNT_W-1:0];
                        state_d     = StWaitByte;
                    end
                end
            end
            StWaitByte: begin
                if (ldr.byte_valid) begin
                    data_d  = ldr.byte_data;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                state_d = StWrite;
            end
            StWrite: begin
                addr_cnt_d  = addr_cnt_q + CNT_W'(1);
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StWaitByte;
                end
            end
            StDone: begin
                if (ldr.start) begin
                    done_d         = 1'b0;
                    length_error_d = 1'b0;
                    addr_cnt_d     = '0;
                    state_d        = StLen;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore output decode; bus is all zeros whenever the loader is not driving it.
    always_comb begin
        byte_ready       = (state_q == StLen) || (state_q == StWaitByte);
        ram_addr_enable  = (state_q == StAddr);
        ram_write_enable = (state_q == StWrite);
        cpu_hold         = (state_q != StIdle) && (state_q != StDone);
        bus_out          = '0;
        // addr_cnt MSB is always 0 in ADDR, so extending the full counter equals the low bits.
        if (state_q == StAddr)  bus_out = WIDTH'(addr_cnt_q);
        if (state_q == StWrite) bus_out = data_q;
    end

    assign ldr.byte_ready       = byte_ready;
    assign ldr.bus_out          = bus_out;
    assign ldr.ram_addr_enable  = ram_addr_enable;
    assign ldr.ram_write_enable = ram_write_enable;
    assign ldr.cpu_hold         = cpu_hold;
    assign ldr.done             = done_q;
    assign ldr.length_error     = length_error_q;

endmodule
